dmem_responder: RTL
===================

# dmem_responder

Data-memory responder for the downsampling processor: services the load/store requests the register file issues on `MEM`, `dm_addr` and `dm_data`. It returns read bytes on `mem_data` with a one-cycle `mem_ready` strobe. Accesses go through a programmable wait-state counter into a single-port synchronous RAM holding the image buffer. It sits between the register file and the image RAM, and replaces direct combinational memory access.

## Interface
Parameters:
- `ADDR_W`, 19, address width (matches `dm_addr`).
- `DATA_W`, 8, byte width (matches `dm_data` / `mem_data`).
- `DEPTH`, 524288, implemented bytes; addresses `>= DEPTH` are out of range.
- `WAIT_CYC`, 1, wait states inserted before the RAM access (0..15).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `MEM`  in  2  operation: 00 idle, 01 load, 10 store, 11 illegal.
- `dm_addr`  in  ADDR_W  byte address.
- `dm_data`  in  DATA_W  store data.
- `mem_data`  out  DATA_W  load data; held until the next load response.
- `mem_ready`  out  1  one-cycle completion strobe (load or store).
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `err`  out  1  valid with `mem_ready`; high for out-of-range address or `MEM`=11.

## Operation
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - When `MEM != 00`, latch op, addr and data, then go to WAIT (`WAIT_CYC>0`) or ACCESS (`WAIT_CYC=0`).
  - When `MEM = 00`, stay in IDLE.
- WAIT: down-counter loaded with `WAIT_CYC-1` on accept. Go to ACCESS when the count is 0.
- ACCESS: one cycle. Present the latched address to `dm_ram`:
  - Store: the write enable is asserted this cycle.
  - Load: the read is issued this cycle.
  - Out-of-range or illegal op: no RAM enable is asserted.
  - Always goes to RESP.
- RESP: one cycle with `mem_ready=1`.
  - Load: `mem_data` takes the RAM output, or 0 on error.
  - Store: `mem_data` is unchanged.
  - `err` is set per the latched error flag. Go to IDLE.
- Inputs are sampled only in IDLE. `MEM` and its operands are ignored while `busy=1`; no queueing.
- The error flag is computed at accept: `addr >= DEPTH` or op = 11.
- RAM contents are never cleared by `rst`.

## Timing
- Reset values: `mem_data=0`, `mem_ready=0`, `busy=0`, `err=0`; state IDLE, counter 0.
- Request accepted at edge N (IDLE, `MEM!=00`):
  - `busy=1` from cycle N+1.
  - ACCESS in cycle N+1+WAIT_CYC.
  - `mem_ready` in cycle N+2+WAIT_CYC.
  - `busy=0` from cycle N+3+WAIT_CYC.
- Latency from accept to `mem_ready` is WAIT_CYC+2 cycles. Maximum throughput is one request per WAIT_CYC+3 cycles.
- `err` and `mem_ready` are both registered and only meaningful together. `err=0` outside RESP.
- `rst` mid-operation:
  - Abort to IDLE next edge; outputs take their reset values.
  - A store whose ACCESS edge already occurred stays committed. A store reset before ACCESS is never written.
- `rst` has priority over a simultaneous request; that request is dropped.

## Structure
- Package `dm_pkg`:
  - `MEM` opcodes (`MEM_IDLE`, `MEM_LOAD`, `MEM_STORE`, `MEM_ILL`).
  - FSM state enum.
  - Default `ADDR_W`/`DATA_W` constants.
- Sub-module `dm_ram`: single-port synchronous RAM (`DEPTH` x `DATA_W`), with one `we` and a registered read, one-cycle read latency. It is behavioural and infers block RAM.
- Top level contains the FSM, wait counter, request latches and output registers.

## Test plan
- Store then load, `WAIT_CYC=1`: store 0xA5 at 19'd10, then load 19'd10 -> `mem_ready` 3 cycles after each accept; `mem_data=0xA5`, `err=0`.
- `WAIT_CYC=0` and `WAIT_CYC=4` back-to-back loads -> `mem_ready` at accept+2 and accept+6; `busy` low exactly one cycle after RESP before the next accept.
- Load from 19'd524287 with `DEPTH=262144` -> `err=1` with `mem_ready`, `mem_data=0`. A store to that address leaves the RAM unchanged.
- `MEM=11` -> `err=1` after WAIT_CYC+2 cycles, with no RAM access. A `MEM=01` applied while `busy=1` is ignored: no second `mem_ready`.
- `rst` asserted one cycle after accepting a store of 0x3C to addr 5 (`WAIT_CYC=2`): outputs return to reset values; a subsequent load of addr 5 returns the old value.
- Reset check: hold `rst` 2 cycles with `MEM=01` -> `busy`, `mem_ready`, `err` and `mem_data` stay 0 throughout.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder: MEM opcodes, FSM states
// and default bus widths.
package dm_pkg;

  localparam int DM_ADDR_W = 19;
  localparam int DM_DATA_W = 8;

  typedef enum logic [1:0] {
    MEM_IDLE  = 2'b00,
    MEM_LOAD  = 2'b01,
    MEM_STORE = 2'b10,
    MEM_ILL   = 2'b11
  } mem_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } dm_state_e;

endpackage

// File: rtl/dm_ram.sv
// Single-port synchronous image RAM with one write enable and a registered
// read (one-cycle latency). Contents are not affected by any reset.
module dm_ram #(
  parameter int DEPTH  = 524288,
  parameter int DATA_W = 8,
  parameter int AW     = 19
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder between the register file and the image RAM: accepts
// one request in IDLE, inserts WAIT_CYC wait states, accesses the RAM, responds.
module dmem_responder
  import dm_pkg::*;
#(
  parameter int ADDR_W   = DM_ADDR_W,
  parameter int DATA_W   = DM_DATA_W,
  parameter int DEPTH    = 524288,
  parameter int WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        MEM,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_data,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic              busy,
  output logic              err
);

  localparam int RAM_AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  dm_state_e         state, next_state;
  logic [3:0]        wait_cnt;
  mem_op_e           op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              req_err;
  logic              ready_q;
  logic              err_q;
  logic [DATA_W-1:0] data_q;
  logic              ram_we;
  logic              ram_re;
  logic              resp_load;
  logic [DATA_W-1:0] ram_rdata;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (MEM != MEM_IDLE) next_state = (WAIT_CYC > 0) ? S_WAIT : S_ACCESS;
      S_WAIT:   if (wait_cnt == 4'd0) next_state = S_ACCESS;
      S_ACCESS: next_state = S_RESP;
      S_RESP:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Operands are captured only on accept; the error flag is decided here so
  // the RAM never sees an out-of-range or illegal access.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= 4'd0;
      op_q     <= MEM_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      req_err  <= 1'b0;
    end else if (state == S_IDLE && MEM != MEM_IDLE) begin
      wait_cnt <= WAIT_LOAD;
      op_q     <= mem_op_e'(MEM);
      addr_q   <= dm_addr;
      wdata_q  <= dm_data;
      req_err  <= ({1'b0, dm_addr} >= DEPTH_L) || (MEM == MEM_ILL);
    end else if (state == S_WAIT && wait_cnt != 4'd0) begin
      wait_cnt <= 4'(wait_cnt - 4'd1);
    end
  end

  always_comb begin
    ram_we    = (state == S_ACCESS) && (op_q == MEM_STORE) && !req_err;
    ram_re    = (state == S_ACCESS) && (op_q == MEM_LOAD) && !req_err;
    resp_load = (state == S_RESP) && (op_q == MEM_LOAD);
    busy      = (state != S_IDLE);
    mem_data  = data_q;
    if (resp_load) mem_data = req_err ? '0 : ram_rdata;
  end

  // The RAM read lands during RESP, so load data is forwarded then and held
  // in data_q until the next load response.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      ready_q <= (state == S_ACCESS);
      err_q   <= (state == S_ACCESS) && req_err;
      if (resp_load) data_q <= mem_data;
    end
  end

  assign mem_ready = ready_q;
  assign err       = err_q;

  dm_ram #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .AW    (RAM_AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .re   (ram_re),
    .addr (addr_q[RAM_AW-1:0]),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

endmodule
